// File: rtl/axis_adc_stream_arbiter_if.sv
// Stream bundle around the ADC arbiter: NUM_CH packed source lanes in, one merged lane out.
// The master modport is the arbiter's view. The slave modport is the view of the sources and sink around it.
interface axis_adc_stream_arbiter_if #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ID_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) ();

    logic [NUM_CH*DATA_WIDTH-1:0] s_axis_tdata;
    logic [NUM_CH-1:0]            s_axis_tvalid;
    logic [NUM_CH-1:0]            s_axis_tlast;
    logic [NUM_CH-1:0]            s_axis_tready;

    logic [DATA_WIDTH-1:0]        m_axis_tdata;
    logic [DATA_WIDTH/8-1:0]      m_axis_tstrb;
    logic [DATA_WIDTH/8-1:0]      m_axis_tkeep;
    logic                         m_axis_tvalid;
    logic                         m_axis_tlast;
    logic [ID_W-1:0]              m_axis_tid;
    logic                         m_axis_tready;

    modport master (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tstrb, m_axis_tkeep,
               m_axis_tvalid, m_axis_tlast, m_axis_tid
    );

    modport slave (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tstrb, m_axis_tkeep,
               m_axis_tvalid, m_axis_tlast, m_axis_tid
    );

endinterface

// File: rtl/axis_adc_stream_arbiter.sv
// Packet-level round-robin merge of NUM_CH ADC streams into one tagged AXI-Stream output.
// Grants change only on packet boundaries, and packets longer than MAX_PKT_LEN are cut and flagged.
module axis_adc_stream_arbiter #(
    parameter int NUM_CH      = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int MAX_PKT_LEN = 64,
    parameter int ID_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     m_axis_aclk,
    input  logic                     m_axis_areset,
    input  logic [NUM_CH-1:0]        ch_enable,
    axis_adc_stream_arbiter_if.master axis,
    output logic                     busy,
    output logic                     pkt_done,
    output logic [NUM_CH-1:0]        err_overlen
);

    localparam int CNT_W = $clog2(MAX_PKT_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_PKT_LEN - 1);

    typedef enum logic {
        ST_ARB,
        ST_XFER
    } state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [NUM_CH-1:0] err_q, err_d;
    logic              pkt_done_q, pkt_done_d;

    logic [DATA_WIDTH-1:0] src_data [NUM_CH];
    logic [NUM_CH-1:0]     cand;
    logic                  cand_found;
    logic [ID_W-1:0]       cand_idx;
    logic [ID_W-1:0]       search_idx;
    logic                  xfer;
    logic                  src_last;
    logic                  beat_limit;
    logic                  hs;

    always_comb begin : unpack_sources
        for (int k = 0; k < NUM_CH; k++) begin
            src_data[k] = axis.s_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Walk the offsets from the far end down, so the candidate closest to rr_ptr is the one kept.
    always_comb begin : rr_search
        // NOTE: every variable gets a default before any branch; otherwise the tool infers a latch.
        cand       = axis.s_axis_tvalid & ch_enable;
        cand_found = 1'b0;
        cand_idx   = rr_ptr_q;
        search_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            search_idx = ID_W'((int'(rr_ptr_q) + i) % NUM_CH);
            if (cand[search_idx]) begin
                cand_found = 1'b1;
                cand_idx   = search_idx;
            end
        end
    end

    // Zero-latency pass-through: the output beat is the granted source's beat in the same cycle.
    always_comb begin : datapath
        xfer       = (state_q == ST_XFER);
        src_last   = axis.s_axis_tlast[grant_q];
        beat_limit = (beat_cnt_q == LAST_BEAT);

        axis.m_axis_tdata  = src_data[grant_q];
        axis.m_axis_tvalid = xfer & axis.s_axis_tvalid[grant_q];
        axis.m_axis_tlast  = xfer & (src_last | beat_limit);
        axis.m_axis_tid    = grant_q;
        axis.m_axis_tstrb  = '1;
        axis.m_axis_tkeep  = '1;

        axis.s_axis_tready = '0;
        if (xfer) begin
            axis.s_axis_tready[grant_q] = axis.m_axis_tready;
        end

        hs = axis.m_axis_tvalid & axis.m_axis_tready;
    end

    always_comb begin : fsm_next
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;
        pkt_done_d = 1'b0;

        unique case (state_q)
            ST_ARB: begin
                // ch_enable counts only here, so disabling a channel mid-packet cannot truncate it.
                if (cand_found) begin
                    grant_d    = cand_idx;
                    beat_cnt_d = '0;
                    state_d    = ST_XFER;
                end
            end
            ST_XFER: begin
                if (hs) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (beat_limit && !src_last) begin
                        err_d[grant_q] = 1'b1;
                    end
                    if (axis.m_axis_tlast) begin
                        state_d    = ST_ARB;
                        rr_ptr_d   = ID_W'((int'(grant_q) + 1) % NUM_CH);
                        pkt_done_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge m_axis_aclk) begin
        // NOTE: state registers take non-blocking assignments, so every register samples the pre-edge values.
        if (m_axis_areset) begin
            state_q    <= ST_ARB;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            err_q      <= '0;
            pkt_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
            pkt_done_q <= pkt_done_d;
        end
    end

    assign busy        = (state_q == ST_XFER);
    assign pkt_done    = pkt_done_q;
    assign err_overlen = err_q;

endmodule

// File: tb/tb_axis_adc_stream_arbiter.sv
// Directed bench for axis_adc_stream_arbiter: per-channel packet sources plus an output beat log.
// Each test task drives its own scenario and compares the logged beats against hand-derived values.
module tb_axis_adc_stream_arbiter;

    localparam int NUM_CH  = 4;
    localparam int DW      = 16;
    localparam int MAX_LEN = 64;
    localparam int ID_W    = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] ch_enable;
    logic              busy;
    logic              pkt_done;
    logic [NUM_CH-1:0] err_overlen;

    always #5 clk = ~clk;

    axis_adc_stream_arbiter_if #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .ID_W(ID_W)) bus ();

    axis_adc_stream_arbiter #(
        .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .MAX_PKT_LEN(MAX_LEN), .ID_W(ID_W)
    ) dut (
        .m_axis_aclk  (clk),
        .m_axis_areset(rst),
        .ch_enable    (ch_enable),
        .axis         (bus.master),
        .busy         (busy),
        .pkt_done     (pkt_done),
        .err_overlen  (err_overlen)
    );

    typedef struct {
        logic [DW-1:0]   data;
        logic [ID_W-1:0] tid;
        logic            last;
        int              cyc;
    } beat_t;

    beat_t       log_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          pkt_done_cnt = 0;
    int          src_len  [NUM_CH];
    int          src_beat [NUM_CH];
    int          src_pkts [NUM_CH];
    logic [DW-1:0] src_data [NUM_CH];
    logic        lfsr_mode;
    logic [5:0]  lfsr;
    logic        check_ready;

    task automatic drive_inputs();
        for (int k = 0; k < NUM_CH; k++) begin
            bus.s_axis_tvalid[k]          = (src_pkts[k] > 0);
            bus.s_axis_tdata[k*DW +: DW]  = src_data[k];
            bus.s_axis_tlast[k]           = (src_beat[k] == src_len[k] - 1);
        end
        bus.m_axis_tready = lfsr_mode ? lfsr[0] : 1'b1;
    endtask

    // Sample at the falling edge, let the rising edge commit, then advance the sources that handshook.
    task automatic tick();
        logic [NUM_CH-1:0] hs;
        beat_t b;
        @(negedge clk);
        hs = bus.s_axis_tvalid & bus.s_axis_tready;
        if (bus.m_axis_tvalid === 1'b1 && bus.m_axis_tready === 1'b1) begin
            b.data = bus.m_axis_tdata;
            b.tid  = bus.m_axis_tid;
            b.last = bus.m_axis_tlast;
            b.cyc  = cyc;
            log_q.push_back(b);
        end
        if (pkt_done === 1'b1) pkt_done_cnt++;
        if (check_ready) begin
            vectors++;
            if ($countones(bus.s_axis_tready) > 1 ||
                (bus.s_axis_tready & ~(NUM_CH'(1) << bus.m_axis_tid)) != '0) begin
                miscompares++;
                $display("FAIL tready_onehot cyc=%0d got=%b tid=%0d", cyc, bus.s_axis_tready,
                         bus.m_axis_tid);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < NUM_CH; k++) begin
            if (hs[k] === 1'b1) begin
                src_data[k]++;
                if (src_beat[k] == src_len[k] - 1) begin
                    src_beat[k] = 0;
                    src_pkts[k]--;
                end else begin
                    src_beat[k]++;
                end
            end
        end
        lfsr = {lfsr[4:0], lfsr[5] ^ lfsr[4]};
        drive_inputs();
    endtask

    task automatic setup();
        for (int k = 0; k < NUM_CH; k++) begin
            src_len[k]  = 8;
            src_beat[k] = 0;
            src_pkts[k] = 0;
            src_data[k] = '0;
        end
        log_q.delete();
        pkt_done_cnt = 0;
        lfsr_mode    = 1'b0;
        lfsr         = 6'h01;
        check_ready  = 1'b0;
        drive_inputs();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        setup();
        rst = 1'b0;
    endtask

    task automatic run_beats(input int n, input int budget, input string name);
        int c = 0;
        while (log_q.size() < n && c < budget) begin
            tick();
            c++;
        end
        vectors++;
        if (log_q.size() < n) begin
            miscompares++;
            $display("FAIL %s_timeout got=%0d beats exp=%0d", name, log_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ch_enable = 4'b1111;
        setup();
        for (int k = 0; k < NUM_CH; k++) src_pkts[k] = 1;
        drive_inputs();
        tick();
        vectors += 7;
        if (bus.m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL rst_tvalid got=%b exp=0", bus.m_axis_tvalid); end
        if (bus.m_axis_tlast !== 1'b0)  begin miscompares++; $display("FAIL rst_tlast got=%b exp=0", bus.m_axis_tlast); end
        if (bus.m_axis_tid !== 2'd0)    begin miscompares++; $display("FAIL rst_tid got=%0d exp=0", bus.m_axis_tid); end
        if (bus.s_axis_tready !== 4'b0) begin miscompares++; $display("FAIL rst_tready got=%b exp=0000", bus.s_axis_tready); end
        if (busy !== 1'b0)              begin miscompares++; $display("FAIL rst_busy got=%b exp=0", busy); end
        if (pkt_done !== 1'b0)          begin miscompares++; $display("FAIL rst_pkt_done got=%b exp=0", pkt_done); end
        if (err_overlen !== 4'b0)       begin miscompares++; $display("FAIL rst_err got=%b exp=0000", err_overlen); end
        rst = 1'b0;
        drive_inputs();
        tick();
        // All four valid with rr_ptr=0: channel 0 is granted on the first free edge.
        vectors += 3;
        if (busy !== 1'b1)                begin miscompares++; $display("FAIL grant_busy got=%b exp=1", busy); end
        if (bus.m_axis_tid !== 2'd0)      begin miscompares++; $display("FAIL grant_tid got=%0d exp=0", bus.m_axis_tid); end
        if (bus.s_axis_tready !== 4'b0001) begin miscompares++; $display("FAIL grant_tready got=%b exp=0001", bus.s_axis_tready); end
    endtask

    task automatic test_single_channel();
        logic [18:0] got, expv;
        int gap;
        apply_reset();
        ch_enable  = 4'b0001;
        src_len[0] = 64;
        src_pkts[0] = 2;
        drive_inputs();
        run_beats(128, 400, "single");
        repeat (3) tick();
        for (int i = 0; i < log_q.size() && i < 128; i++) begin
            got  = {log_q[i].data, log_q[i].tid, log_q[i].last};
            expv = {16'(i), 2'd0, (i % 64 == 63)};
            vectors++;
            if (got !== expv) begin
                miscompares++;
                $display("FAIL single_beat[%0d] got=%h exp=%h", i, got, expv);
            end
            if (i > 0) begin
                gap = (i % 64 == 0) ? 2 : 1;
                vectors++;
                if (log_q[i].cyc - log_q[i-1].cyc != gap) begin
                    miscompares++;
                    $display("FAIL single_gap[%0d] got=%0d exp=%0d", i, log_q[i].cyc - log_q[i-1].cyc, gap);
                end
            end
        end
        vectors += 2;
        if (pkt_done_cnt != 2) begin miscompares++; $display("FAIL single_pkt_done got=%0d exp=2", pkt_done_cnt); end
        if (err_overlen !== 4'b0) begin miscompares++; $display("FAIL single_err got=%b exp=0000", err_overlen); end
    endtask

    task automatic test_fairness();
        logic [18:0] got, expv;
        int p, gap;
        apply_reset();
        ch_enable = 4'b1111;
        for (int k = 0; k < NUM_CH; k++) src_pkts[k] = 3;
        drive_inputs();
        check_ready = 1'b1;
        run_beats(96, 300, "fair");
        repeat (2) tick();
        check_ready = 1'b0;
        for (int i = 0; i < log_q.size() && i < 96; i++) begin
            p    = i / 8;
            got  = {log_q[i].data, log_q[i].tid, log_q[i].last};
            expv = {16'((p / 4) * 8 + i % 8), 2'(p % 4), (i % 8 == 7)};
            vectors++;
            if (got !== expv) begin
                miscompares++;
                $display("FAIL fair_beat[%0d] got=%h exp=%h", i, got, expv);
            end
            if (i > 0) begin
                gap = (i % 8 == 0) ? 2 : 1;
                vectors++;
                if (log_q[i].cyc - log_q[i-1].cyc != gap) begin
                    miscompares++;
                    $display("FAIL fair_gap[%0d] got=%0d exp=%0d", i, log_q[i].cyc - log_q[i-1].cyc, gap);
                end
            end
        end
        vectors++;
        if (pkt_done_cnt != 12) begin miscompares++; $display("FAIL fair_pkt_done got=%0d exp=12", pkt_done_cnt); end
    endtask

    task automatic test_backpressure();
        int exp_cnt [NUM_CH];
        int t;
        apply_reset();
        ch_enable = 4'b1111;
        for (int k = 0; k < NUM_CH; k++) begin
            src_len[k]  = 64;
            src_pkts[k] = 2;
            exp_cnt[k]  = 0;
        end
        lfsr_mode = 1'b1;
        drive_inputs();
        run_beats(512, 3000, "bp");
        repeat (4) tick();
        lfsr_mode = 1'b0;
        for (int i = 0; i < log_q.size(); i++) begin
            t = int'(log_q[i].tid);
            vectors++;
            if (log_q[i].data !== 16'(exp_cnt[t]) || log_q[i].last !== (exp_cnt[t] % 64 == 63)) begin
                miscompares++;
                $display("FAIL bp_beat[%0d] tid=%0d got=%h/%b exp=%h/%b", i, t, log_q[i].data,
                         log_q[i].last, 16'(exp_cnt[t]), (exp_cnt[t] % 64 == 63));
            end
            exp_cnt[t]++;
        end
        for (int k = 0; k < NUM_CH; k++) begin
            vectors++;
            if (exp_cnt[k] != 128) begin
                miscompares++;
                $display("FAIL bp_count ch%0d got=%0d exp=128", k, exp_cnt[k]);
            end
        end
        vectors++;
        if (err_overlen !== 4'b0) begin miscompares++; $display("FAIL bp_err got=%b exp=0000", err_overlen); end
    endtask

    task automatic test_enable_change();
        logic [18:0] got, expv;
        int c = 0;
        apply_reset();
        ch_enable   = 4'b0011;
        src_len[0]  = 16;
        src_len[1]  = 16;
        src_pkts[1] = 2;
        drive_inputs();
        while (log_q.size() < 48 && c < 300) begin
            tick();
            c++;
            if (log_q.size() == 10 && ch_enable[1]) begin
                ch_enable[1] = 1'b0;
                src_pkts[0]  = 2;
                drive_inputs();
            end
        end
        repeat (20) tick();
        vectors++;
        if (log_q.size() != 48) begin
            miscompares++;
            $display("FAIL en_beat_count got=%0d exp=48", log_q.size());
        end
        for (int i = 0; i < log_q.size() && i < 48; i++) begin
            got = {log_q[i].data, log_q[i].tid, log_q[i].last};
            if (i < 16) expv = {16'(i), 2'd1, (i == 15)};
            else        expv = {16'(i - 16), 2'd0, ((i - 16) % 16 == 15)};
            vectors++;
            if (got !== expv) begin
                miscompares++;
                $display("FAIL en_beat[%0d] got=%h exp=%h", i, got, expv);
            end
        end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL en_disabled_granted busy got=%b exp=0", busy); end
    endtask

    task automatic test_overlength();
        logic [18:0] got, expv;
        apply_reset();
        ch_enable   = 4'b0100;
        src_len[2]  = 70;
        src_pkts[2] = 1;
        drive_inputs();
        run_beats(70, 300, "ovl");
        repeat (3) tick();
        for (int i = 0; i < log_q.size() && i < 70; i++) begin
            got  = {log_q[i].data, log_q[i].tid, log_q[i].last};
            expv = {16'(i), 2'd2, (i == 63 || i == 69)};
            vectors++;
            if (got !== expv) begin
                miscompares++;
                $display("FAIL ovl_beat[%0d] got=%h exp=%h", i, got, expv);
            end
        end
        vectors += 3;
        if (log_q.size() >= 65 && log_q[64].cyc - log_q[63].cyc != 2) begin
            miscompares++;
            $display("FAIL ovl_split_gap got=%0d exp=2", log_q[64].cyc - log_q[63].cyc);
        end
        if (err_overlen !== 4'b0100) begin miscompares++; $display("FAIL ovl_err got=%b exp=0100", err_overlen); end
        if (pkt_done_cnt != 2) begin miscompares++; $display("FAIL ovl_pkt_done got=%0d exp=2", pkt_done_cnt); end
        repeat (5) tick();
        vectors++;
        if (err_overlen !== 4'b0100) begin miscompares++; $display("FAIL ovl_err_sticky got=%b exp=0100", err_overlen); end
    endtask

    // Runs straight after the overlength test, so err_overlen and rr_ptr=3 carry in un-reset.
    task automatic test_reset_mid_packet();
        logic [18:0] got, expv;
        int c = 0;
        setup();
        ch_enable   = 4'b1111;
        src_len[3]  = 64;
        src_pkts[3] = 1;
        drive_inputs();
        while (log_q.size() < 20 && c < 200) begin
            tick();
            c++;
        end
        vectors += 3;
        if (log_q.size() < 20) begin miscompares++; $display("FAIL rmp_timeout got=%0d exp=20", log_q.size()); end
        if (log_q.size() > 0 && log_q[0].tid !== 2'd3) begin miscompares++; $display("FAIL rmp_first_tid got=%0d exp=3", log_q[0].tid); end
        if (err_overlen !== 4'b0100) begin miscompares++; $display("FAIL rmp_err_before got=%b exp=0100", err_overlen); end
        rst = 1'b1;
        tick();
        vectors += 5;
        if (bus.m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL rmp_tvalid got=%b exp=0", bus.m_axis_tvalid); end
        if (bus.s_axis_tready !== 4'b0) begin miscompares++; $display("FAIL rmp_tready got=%b exp=0000", bus.s_axis_tready); end
        if (err_overlen !== 4'b0)       begin miscompares++; $display("FAIL rmp_err got=%b exp=0000", err_overlen); end
        if (busy !== 1'b0)              begin miscompares++; $display("FAIL rmp_busy got=%b exp=0", busy); end
        if (bus.m_axis_tid !== 2'd0)    begin miscompares++; $display("FAIL rmp_tid got=%0d exp=0", bus.m_axis_tid); end
        setup();
        for (int k = 1; k < NUM_CH; k++) begin
            src_len[k]  = 4;
            src_pkts[k] = 1;
        end
        rst = 1'b0;
        drive_inputs();
        run_beats(4, 50, "rmp_restart");
        for (int i = 0; i < log_q.size() && i < 4; i++) begin
            got  = {log_q[i].data, log_q[i].tid, log_q[i].last};
            expv = {16'(i), 2'd1, (i == 3)};
            vectors++;
            if (got !== expv) begin
                miscompares++;
                $display("FAIL rmp_restart_beat[%0d] got=%h exp=%h", i, got, expv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_fairness();
        test_backpressure();
        test_enable_change();
        test_overlength();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axis_adc_stream_arbiter.md
# axis_adc_stream_arbiter

Packet-level round-robin arbiter that merges up to NUM_CH ADC AXI-Stream sources into one AXI-Stream master output. Each source is an ADC capture path that emits 16-bit samples in fixed-length packets terminated by tlast. The arbiter grants one source at a time and always switches on packet boundaries. It tags every output beat with the source index and enforces a maximum packet length. It sits between the per-channel ADC stream blocks and the shared DMA/stream sink.

## Interface
- NUM_CH, 4, number of source streams (2..8)
- DATA_WIDTH, 16, sample width in bits (multiple of 8)
- MAX_PKT_LEN, 64, maximum beats per output packet; a longer source packet is force-terminated
- ID_W, max(1, clog2(NUM_CH)), width of m_axis_tid
- m_axis_aclk  in  1  single clock for all logic
- m_axis_areset  in  1  synchronous, active-high reset
- ch_enable  in  NUM_CH  per-channel enable mask, sampled only during arbitration
- s_axis_tdata  in  NUM_CH*DATA_WIDTH  packed source data; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
- s_axis_tvalid  in  NUM_CH  per-source valid
- s_axis_tlast  in  NUM_CH  per-source end of packet
- s_axis_tready  out  NUM_CH  per-source ready
- m_axis_tdata  out  DATA_WIDTH  merged data
- m_axis_tstrb  out  DATA_WIDTH/8  constant all ones
- m_axis_tkeep  out  DATA_WIDTH/8  constant all ones
- m_axis_tvalid  out  1  merged valid
- m_axis_tlast  out  1  end of output packet (source tlast, or forced)
- m_axis_tid  out  ID_W  index of the granted source
- m_axis_tready  in  1  sink ready
- busy  out  1  high while in XFER
- pkt_done  out  1  one-cycle pulse after each output packet completes
- err_overlen  out  NUM_CH  sticky per-channel flag: the channel exceeded MAX_PKT_LEN

## Operation
- FSM has two states, ARB and XFER. Registers: state, grant[ID_W], rr_ptr[ID_W], beat_cnt[clog2(MAX_PKT_LEN+1)], err_overlen, pkt_done.
- Candidate set = s_axis_tvalid & ch_enable.
- ARB: if the candidate set is non-empty, choose the first candidate found searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, … NUM_CH-1, 0, …). Load grant with that index, clear beat_cnt, and go to XFER. If the set is empty, stay in ARB.
- In ARB, m_axis_tvalid=0 and s_axis_tready is all zeros.
- XFER datapath is a combinational pass-through from the granted source:
  - m_axis_tdata = source data[grant]
  - m_axis_tvalid = s_axis_tvalid[grant]
  - s_axis_tready[grant] = m_axis_tready; every other tready bit is 0
  - m_axis_tid = grant
- Handshake = m_axis_tvalid & m_axis_tready. Each handshake increments beat_cnt.
- m_axis_tlast = s_axis_tlast[grant] OR (beat_cnt == MAX_PKT_LEN-1).
- On a handshake with m_axis_tlast=1:
  - state goes to ARB
  - rr_ptr = (grant+1) mod NUM_CH
  - pkt_done pulses on the next cycle
- Forced termination: if beat_cnt == MAX_PKT_LEN-1 and the source tlast is 0, set err_overlen[grant]. The remaining beats of that source packet are arbitrated later as a new packet.
- ch_enable is ignored during XFER. Deasserting a channel's enable mid-packet never truncates the packet.
- A source tvalid that drops mid-packet stalls the output; the grant is held, with no timeout.
- err_overlen bits clear only on reset.

## Timing
- Reset (synchronous, same edge) sets: state=ARB, grant=0, rr_ptr=0, beat_cnt=0, err_overlen=0, pkt_done=0. Resulting outputs: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tid=0, s_axis_tready=0, busy=0.
- Reset asserted mid-packet abandons the packet. The sink sees tvalid drop with no tlast. Arbitration restarts at channel 0.
- Grant latency: a candidate visible in ARB at edge N is granted at edge N. Its first beat can transfer in cycle N+1.
- Exactly one dead cycle (ARB) occurs between consecutive output packets. Sustained throughput is L/(L+1) for L-beat packets.
- Zero data latency: output beat fields are combinational from the granted source within the cycle.
- A candidate that asserts tvalid and tlast in the same cycle it is granted is a valid 1-beat packet.
- With NUM_CH=1, the arbiter degenerates to pass-through plus a dead cycle and the length watchdog.

## Test plan
- Single channel: ch_enable=0001, ch0 sends 64-beat packets with data 0..63 (tlast on 63), tready=1. Required: 64 output beats with tid=0 and tlast on beat 63, one dead cycle, then the next packet. pkt_done pulses once per packet.
- Fairness: ch_enable=1111, all four sources continuously valid with 8-beat packets. Required: tid sequence 0,1,2,3,0,1…, each packet contiguous, and s_axis_tready asserted only for the granted channel.
- Backpressure: 6-bit LFSR on m_axis_tready, each channel sending incrementing data. Required: per-tid data strictly +1 with no loss or duplication, and tlast every 64 beats per channel.
- Overlength: MAX_PKT_LEN=64, ch2 sends 70 beats with tlast on beat 69. Required: forced tlast on output beat 63, err_overlen=0100 sticky, and the remaining 6 beats emitted later as a separate tid=2 packet.
- Enable change mid-packet: clear ch_enable[1] during beat 10 of a ch1 packet. Required: the ch1 packet completes in full, and ch1 is never granted again while disabled.
- Reset mid-packet: assert m_axis_areset at beat 20 of a ch3 packet. Required: the next edge gives tvalid=0, tready=0, err_overlen=0, and after release the first grant goes to the lowest enabled valid channel starting from 0.
